// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store arbiter in front of the SPI memory stage.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned MEM_ADDR_W     = 25;
    localparam int unsigned NUM_BYTES_W    = 3;
    localparam int unsigned RAM_SEL_BIT    = 24;
    localparam int unsigned ADDR_LIMIT_BIT = 25;
    localparam logic [NUM_BYTES_W-1:0] FETCH_BYTES = NUM_BYTES_W'(4);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } ls_size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BUSY = 3'b010,
        ST_DONE = 3'b100
    } state_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]  address;
        logic [NUM_BYTES_W-1:0] num_bytes;
        logic                   is_write;
        logic [DATA_W-1:0]      write_value;
    } mem_req_t;

    function automatic logic [NUM_BYTES_W-1:0] size_to_bytes(input ls_size_e size);
        case (size)
            SZ_BYTE: return NUM_BYTES_W'(1);
            SZ_HALF: return NUM_BYTES_W'(2);
            SZ_WORD: return NUM_BYTES_W'(4);
            default: return NUM_BYTES_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports (fetch + load/store) and SPI memory stage ports of the arbiter.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;

    logic        ls_req;
    logic        ls_is_write;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        ls_fault;

    logic        mem_start;
    logic [2:0]  mem_num_bytes;
    logic [24:0] mem_address;
    logic        mem_is_write;
    logic [31:0] mem_write_value;
    logic        mem_done;
    logic [31:0] mem_data;

    // Arbiter side: serves the requesters and masters the SPI stage.
    modport master (
        input  if_req, if_addr, ls_req, ls_is_write, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  mem_done, mem_data,
        output if_data, if_done, ls_rdata, ls_done, ls_fault,
        output mem_start, mem_num_bytes, mem_address, mem_is_write, mem_write_value
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_is_write, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output mem_done, mem_data,
        input  if_data, if_done, ls_rdata, ls_done, ls_fault,
        input  mem_start, mem_num_bytes, mem_address, mem_is_write, mem_write_value
    );

endinterface

// File: rtl/mem_arbiter_load_align.sv
// Picks the received bytes from the top of the SPI word and sign/zero-extends them to 32 bits.
module load_align
    import mem_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] mem_data,
    input  ls_size_e          size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] result_c
);

    logic ext_b;
    logic ext_h;

    assign ext_b = ~is_unsigned & mem_data[31];
    assign ext_h = ~is_unsigned & mem_data[31];

    always_comb begin
        result_c = mem_data;
        case (size)
            SZ_BYTE: result_c = {{24{ext_b}}, mem_data[31:24]};
            SZ_HALF: result_c = {{16{ext_h}}, mem_data[31:16]};
            default: result_c = mem_data;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto a single SPI memory stage; load/store wins ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    state_e            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              start_q, start_d;
    logic              grant_ls_q, grant_ls_d;
    ls_size_e          size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic              ls_fault_q, ls_fault_d;

    ls_size_e          ls_size;
    logic              ls_reject;
    logic              if_oob;
    logic [DATA_W-1:0] aligned;

    assign ls_size   = ls_size_e'(bus.ls_size);
    assign ls_reject = (|bus.ls_addr[ADDR_W-1:ADDR_LIMIT_BIT])
                     || (bus.ls_is_write && !bus.ls_addr[RAM_SEL_BIT])
                     || (ls_size == SZ_RSVD);
    assign if_oob    = |bus.if_addr[ADDR_W-1:ADDR_LIMIT_BIT];

    load_align u_load_align (
        .mem_data    (bus.mem_data),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result_c    (aligned)
    );

    // State and every output are registered; reset clears them without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            start_q    <= 1'b0;
            grant_ls_q <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            ls_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            start_q    <= start_d;
            grant_ls_q <= grant_ls_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            ls_fault_q <= ls_fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        start_d    = start_q;
        grant_ls_d = grant_ls_q;
        size_d     = size_q;
        uns_d      = uns_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        ls_fault_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.ls_req) begin
                    grant_ls_d = 1'b1;
                    if (ls_reject) begin
                        state_d    = ST_DONE;
                        ls_done_d  = 1'b1;
                        ls_fault_d = 1'b1;
                        ls_rdata_d = '0;
                    end else begin
                        req_d.address     = bus.ls_addr[MEM_ADDR_W-1:0];
                        req_d.num_bytes   = size_to_bytes(ls_size);
                        req_d.is_write    = bus.ls_is_write;
                        req_d.write_value = bus.ls_wdata;
                        size_d            = ls_size;
                        uns_d             = bus.ls_unsigned;
                        start_d           = 1'b1;
                        state_d           = ST_BUSY;
                    end
                end else if (bus.if_req) begin
                    grant_ls_d = 1'b0;
                    if (if_oob) begin
                        state_d   = ST_DONE;
                        if_done_d = 1'b1;
                        if_data_d = '0;
                    end else begin
                        req_d.address     = bus.if_addr[MEM_ADDR_W-1:0];
                        req_d.num_bytes   = FETCH_BYTES;
                        req_d.is_write    = 1'b0;
                        req_d.write_value = '0;
                        size_d            = SZ_WORD;
                        uns_d             = 1'b1;
                        start_d           = 1'b1;
                        state_d           = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mem_done) begin
                    start_d = 1'b0;
                    state_d = ST_DONE;
                    if (grant_ls_q) begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = req_q.is_write ? '0 : aligned;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = aligned;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_start       = start_q;
    assign bus.mem_address     = req_q.address;
    assign bus.mem_num_bytes   = req_q.num_bytes;
    assign bus.mem_is_write    = req_q.is_write;
    assign bus.mem_write_value = req_q.write_value;
    assign bus.if_data         = if_data_q;
    assign bus.if_done         = if_done_q;
    assign bus.ls_rdata        = ls_rdata_q;
    assign bus.ls_done         = ls_done_q;
    assign bus.ls_fault        = ls_fault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SPI-stage responder with an address-hashed memory, arithmetic reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    mem_arbiter_if bus ();

    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    bit          spi_hold    = 1'b0;
    bit          force_en    = 1'b0;
    logic [31:0] force_data  = '0;
    logic [31:0] salt        = 32'h1234_5678;
    int          spi_starts  = 0;
    int          low_run     = 0;
    int          last_gap    = -1;
    bit          seen_high   = 1'b0;

    typedef struct {
        bit          fault;
        int          nbytes;
        logic [31:0] rdata;
    } ls_exp_t;

    // Contents of the memory behind the SPI stage, as a word seen with its bytes MSB-first.
    function automatic logic [31:0] mem_word(input logic [24:0] a);
        return ({7'b0, a} * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic ls_exp_t model_ls(input bit wr, input logic [1:0] sz, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] word);
        ls_exp_t e;
        longint  val;
        int      bits;
        e.fault  = (addr >= 32'h0200_0000) || (wr && addr < 32'h0100_0000) || (sz == 2'd3);
        e.nbytes = (sz == 2'd3) ? 0 : (1 << sz);
        e.rdata  = '0;
        if (!e.fault && !wr) begin
            bits = 8 * e.nbytes;
            val  = longint'({32'b0, word} >> (32 - bits));
            if (!uns && val >= (64'sd1 << (bits - 1)))
                val = val - (64'sd1 << bits);
            e.rdata = val[31:0];
        end
        return e;
    endfunction

    // SPI stage: answers each mem_start after 0..3 extra cycles unless held.
    initial begin : spi_model
        int lat;
        bit active;
        lat          = 0;
        active       = 1'b0;
        bus.mem_done = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_done) begin
                bus.mem_done = 1'b0;
                active       = 1'b0;
            end else if (rst || !bus.mem_start) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    lat    = int'($urandom_range(0, 3));
                    spi_starts++;
                end
                if (!spi_hold) begin
                    if (lat == 0) begin
                        bus.mem_data = force_en ? force_data : mem_word(bus.mem_address);
                        bus.mem_done = 1'b1;
                    end else begin
                        lat--;
                    end
                end
            end
        end
    end

    // Length of the most recent low stretch of mem_start between two requests.
    initial begin : gap_mon
        forever begin
            @(negedge clk);
            if (rst) begin
                low_run   = 0;
                seen_high = 1'b0;
            end else if (bus.mem_start) begin
                if (seen_high && low_run > 0) last_gap = low_run;
                low_run   = 0;
                seen_high = 1'b1;
            end else begin
                low_run++;
            end
        end
    end

    task automatic ls_txn(input string name, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        ls_exp_t     e;
        logic [31:0] word;
        int          starts0;
        bit          done;
        word    = force_en ? force_data : mem_word(addr[24:0]);
        e       = model_ls(wr, sz, uns, addr, word);
        starts0 = spi_starts;
        @(negedge clk);
        bus.ls_req      = 1'b1;
        bus.ls_is_write = wr;
        bus.ls_size     = sz;
        bus.ls_unsigned = uns;
        bus.ls_addr     = addr;
        bus.ls_wdata    = wdata;
        done            = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.mem_start) begin
                vectors++;
                if (bus.mem_address !== addr[24:0] || bus.mem_num_bytes !== 3'(e.nbytes)
                    || bus.mem_is_write !== wr || bus.mem_write_value !== wdata) begin
                    miscompares++;
                    $display("FAIL %s mem_req: got addr=%h nb=%0d wr=%b wv=%h, want addr=%h nb=%0d wr=%b wv=%h",
                             name, bus.mem_address, bus.mem_num_bytes, bus.mem_is_write, bus.mem_write_value,
                             addr[24:0], e.nbytes, wr, wdata);
                end
            end
            if (bus.ls_done) done = 1'b1;
        end
        bus.ls_req = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s timeout: got no ls_done, want ls_done within 40 cycles", name);
        end else begin
            vectors++;
            if (bus.ls_fault !== e.fault || bus.if_done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s fault: got ls_fault=%b if_done=%b, want ls_fault=%b if_done=0",
                         name, bus.ls_fault, bus.if_done, e.fault);
            end
            if (e.fault || !wr) begin
                vectors++;
                if (bus.ls_rdata !== e.rdata) begin
                    miscompares++;
                    $display("FAIL %s rdata: got %h, want %h", name, bus.ls_rdata, e.rdata);
                end
            end
            vectors++;
            if (spi_starts - starts0 != (e.fault ? 0 : 1)) begin
                miscompares++;
                $display("FAIL %s mem_starts: got %0d, want %0d", name, spi_starts - starts0, e.fault ? 0 : 1);
            end
            @(negedge clk);
            vectors++;
            if (bus.ls_done !== 1'b0 || bus.ls_fault !== 1'b0 || (( e.fault || !wr) && bus.ls_rdata !== e.rdata)) begin
                miscompares++;
                $display("FAIL %s after_done: got ls_done=%b ls_fault=%b rdata=%h, want 0 0 rdata held",
                         name, bus.ls_done, bus.ls_fault, bus.ls_rdata);
            end
        end
    endtask

    task automatic if_txn(input string name, input logic [31:0] addr);
        logic [31:0] exp;
        int          starts0;
        bit          done;
        bit          oob;
        oob     = (addr[31:25] != 7'd0);
        exp     = oob ? 32'h0 : (force_en ? force_data : mem_word(addr[24:0]));
        starts0 = spi_starts;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        done        = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.mem_start) begin
                vectors++;
                if (bus.mem_address !== addr[24:0] || bus.mem_num_bytes !== 3'd4 || bus.mem_is_write !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s mem_req: got addr=%h nb=%0d wr=%b, want addr=%h nb=4 wr=0",
                             name, bus.mem_address, bus.mem_num_bytes, bus.mem_is_write, addr[24:0]);
                end
            end
            if (bus.if_done) done = 1'b1;
        end
        bus.if_req = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s timeout: got no if_done, want if_done within 40 cycles", name);
        end else begin
            vectors++;
            if (bus.if_data !== exp || bus.ls_done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s if_data: got %h ls_done=%b, want %h ls_done=0", name, bus.if_data, bus.ls_done, exp);
            end
            vectors++;
            if (spi_starts - starts0 != (oob ? 0 : 1)) begin
                miscompares++;
                $display("FAIL %s mem_starts: got %0d, want %0d", name, spi_starts - starts0, oob ? 0 : 1);
            end
            @(negedge clk);
            vectors++;
            if (bus.if_done !== 1'b0 || bus.if_data !== exp) begin
                miscompares++;
                $display("FAIL %s after_done: got if_done=%b if_data=%h, want 0 %h", name, bus.if_done, bus.if_data, exp);
            end
        end
    endtask

    task automatic test_reset;
        rst             = 1'b1;
        bus.if_req      = 1'b0;
        bus.if_addr     = '0;
        bus.ls_req      = 1'b0;
        bus.ls_is_write = 1'b0;
        bus.ls_size     = 2'b00;
        bus.ls_unsigned = 1'b0;
        bus.ls_addr     = '0;
        bus.ls_wdata    = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.mem_start, bus.if_done, bus.ls_done, bus.ls_fault, bus.mem_is_write} !== 5'b0
            || bus.if_data !== 32'h0 || bus.ls_rdata !== 32'h0 || bus.mem_address !== 25'h0
            || bus.mem_num_bytes !== 3'h0 || bus.mem_write_value !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: got start=%b done=%b/%b fault=%b addr=%h, want all zero",
                     bus.mem_start, bus.if_done, bus.ls_done, bus.ls_fault, bus.mem_address);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed_loads;
        force_en   = 1'b1;
        force_data = 32'h8899_AABB;
        ls_txn("word_load", 1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0);
        force_data = 32'hF012_3456;
        ls_txn("signed_byte", 1'b0, 2'b00, 1'b0, 32'h0100_0020, 32'h0);
        force_data = 32'h8001_7777;
        ls_txn("unsigned_half", 1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0);
        force_data = 32'h8001_7777;
        ls_txn("signed_half", 1'b0, 2'b01, 1'b0, 32'h0100_0022, 32'h0);
        force_en = 1'b0;
    endtask

    task automatic test_faults;
        ls_txn("store_flash", 1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF);
        ls_txn("load_oob", 1'b0, 2'b10, 1'b0, 32'h0200_0000, 32'h0);
        ls_txn("size_rsvd", 1'b0, 2'b11, 1'b0, 32'h0100_0000, 32'h0);
        ls_txn("store_ram", 1'b1, 2'b10, 1'b0, 32'h0100_0004, 32'hCAFE_F00D);
        if_txn("fetch_oob", 32'h8000_0000);
        if_txn("fetch_flash", 32'h0000_0100);
    endtask

    task automatic test_simultaneous;
        logic [31:0] la, ia, t, iw;
        logic [24:0] exp_addr;
        ls_exp_t     e;
        int          ls_at, if_at;
        force_en = 1'b0;
        t  = $urandom;
        la = {7'b0, 1'b1, t[23:0]};
        t  = $urandom;
        ia = {7'b0, t[24:0]};
        e  = model_ls(1'b0, 2'b10, 1'b0, la, mem_word(la[24:0]));
        iw = mem_word(ia[24:0]);
        @(negedge clk);
        bus.ls_req      = 1'b1;
        bus.ls_is_write = 1'b0;
        bus.ls_size     = 2'b10;
        bus.ls_unsigned = 1'b0;
        bus.ls_addr     = la;
        bus.if_req      = 1'b1;
        bus.if_addr     = ia;
        ls_at = -1;
        if_at = -1;
        for (int k = 0; k < 80 && if_at < 0; k++) begin
            @(negedge clk);
            if (bus.mem_start) begin
                exp_addr = (ls_at < 0) ? la[24:0] : ia[24:0];
                vectors++;
                if (bus.mem_address !== exp_addr) begin
                    miscompares++;
                    $display("FAIL simul_addr: got %h, want %h", bus.mem_address, exp_addr);
                end
            end
            if (bus.ls_done && ls_at < 0) begin ls_at = k; bus.ls_req = 1'b0; end
            if (bus.if_done && if_at < 0) begin if_at = k; bus.if_req = 1'b0; end
        end
        bus.ls_req = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (ls_at < 0 || if_at < 0 || ls_at >= if_at) begin
            miscompares++;
            $display("FAIL simul_order: got ls_done@%0d if_done@%0d, want ls first then fetch", ls_at, if_at);
        end
        vectors++;
        if (bus.ls_rdata !== e.rdata || bus.if_data !== iw) begin
            miscompares++;
            $display("FAIL simul_data: got ls=%h if=%h, want ls=%h if=%h", bus.ls_rdata, bus.if_data, e.rdata, iw);
        end
        vectors++;
        if (last_gap < 2) begin
            miscompares++;
            $display("FAIL simul_gap: got %0d low cycles, want >= 2", last_gap);
        end
    endtask

    task automatic test_reset_mid_busy;
        bit seen;
        spi_hold = 1'b1;
        @(negedge clk);
        bus.ls_req      = 1'b1;
        bus.ls_is_write = 1'b0;
        bus.ls_size     = 2'b10;
        bus.ls_addr     = 32'h0100_0100;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.mem_start) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rst_busy_start: got no mem_start, want mem_start within 20 cycles");
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.mem_start !== 1'b0 || bus.ls_done !== 1'b0 || bus.if_done !== 1'b0
            || bus.ls_rdata !== 32'h0 || bus.if_data !== 32'h0 || bus.mem_address !== 25'h0) begin
            miscompares++;
            $display("FAIL rst_async: got start=%b ls_done=%b rdata=%h addr=%h, want all zero",
                     bus.mem_start, bus.ls_done, bus.ls_rdata, bus.mem_address);
        end
        bus.ls_req = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        spi_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.ls_done !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_start !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_quiet: got ls_done=%b if_done=%b start=%b, want 0 0 0",
                         bus.ls_done, bus.if_done, bus.mem_start);
            end
        end
        if_txn("fetch_after_rst", 32'h0000_0040);
    endtask

    task automatic test_random;
        logic [31:0] t, addr;
        for (int i = 0; i < 40; i++) begin
            salt = $urandom;
            t    = $urandom;
            addr = ($urandom_range(0, 7) == 0) ? t : {7'b0, t[24:0]};
            if ($urandom_range(0, 1) == 1)
                ls_txn("rand_ls", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), addr, $urandom);
            else
                if_txn("rand_if", addr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed_loads();
        test_faults();
        test_simultaneous();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 if_req  input  1  instruction-fetch request, level, held until if_done.
REQ-004 if_addr  input  32  fetch byte address.
REQ-005 if_data  output  32  fetched instruction word.
REQ-006 if_done  output  1  one-cycle completion pulse for fetch.
REQ-007 ls_req  input  1  load/store request, level, held until ls_done.
REQ-008 ls_is_write  input  1  1 = store, 0 = load.
REQ-009 ls_size  input  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-010 ls_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-011 ls_addr  input  32  load/store byte address.
REQ-012 ls_wdata  input  32  store data, right-aligned.
REQ-013 ls_rdata  output  32  extended load result.
REQ-014 ls_done  output  1  one-cycle completion pulse for load/store.
REQ-015 ls_fault  output  1  high with ls_done when the access was rejected.
REQ-016 mem_start  output  1  start_request to the SPI memory stage.
REQ-017 mem_num_bytes  output  3  byte count to the SPI stage (1, 2 or 4).
REQ-018 mem_address  output  25  bit 24 = RAM select, bits 23:0 = device address.
REQ-019 mem_is_write  output  1  write flag to the SPI stage.
REQ-020 mem_write_value  output  32  store data to the SPI stage.
REQ-021 mem_done  input  1  request_done from the SPI stage.
REQ-022 mem_data  input  32  fetched_data from the SPI stage.

Function
REQ-023 FSM states: IDLE, BUSY, DONE; one-hot encoding.
REQ-024 IDLE: ls_req has priority over if_req; the winner's address, size and data are latched, and the FSM moves to BUSY.
REQ-025 Fetch: always 4 bytes, read, mem_address = if_addr[24:0].
REQ-026 Load/store byte count: byte = 1, half = 2, word = 4; mem_write_value = ls_wdata unshifted; mem_is_write = ls_is_write.
REQ-027 Fault (address bits 31:25 non-zero, store with address bit 24 = 0 (flash), or ls_size = 11): no memory access; FSM goes IDLE -> DONE; ls_done and ls_fault assert together; ls_rdata = 0.
REQ-028 Fetch with if_addr[31:25] non-zero: no fault port; if_data = 0, if_done pulses.
REQ-029 BUSY: mem_start = 1 and mem_* outputs are stable. When mem_done = 1, mem_data is captured, mem_start falls at that edge, and the FSM moves to DONE.
REQ-030 DONE lasts 1 cycle with the granted done pulse high; DONE -> IDLE. mem_start is low in DONE and IDLE, so every transaction is separated by at least 2 low cycles of mem_start.
REQ-031 The requester drops its req at the edge ending DONE; a req still high in IDLE is a new request.
REQ-032 Read alignment: the SPI stage places N received bytes in the top N bytes of mem_data, so byte = mem_data[31:24], half = mem_data[31:16], word = mem_data[31:0].
REQ-033 Extension of the aligned value to 32 bits follows ls_unsigned; fetches are never extended.
REQ-034 if_data and ls_rdata are registered and hold their value until the next completion of the same port.
REQ-035 Simultaneous if_req and ls_req: load/store is served first, and the fetch is then granted in the following IDLE.
REQ-036 Request dropped during BUSY: the transaction completes, the done pulse is still issued, and the result is discarded by the requester.

Reset
REQ-037 rst forces IDLE immediately, regardless of clock.
REQ-038 rst forces mem_start, if_done, ls_done and ls_fault to 0, and forces if_data, ls_rdata and all mem_* outputs to 0.
REQ-039 Reset mid-BUSY: mem_start drops asynchronously, returning the SPI stage to idle; no done pulse follows.

Structure
REQ-040 Shared package contents: ls_size encodings, state encodings, RAM-select bit index (24), address-map limit bit (25), fetch byte count (4).
REQ-041 Sub-module load_align: combinational byte select plus sign/zero extension (mem_data, size, unsigned -> 32-bit result), instantiated once.

Verification
REQ-042 Word load, ls_addr 0x0100_0010, mem_data 0x8899AABB -> mem_address 0x1000010, num_bytes 4, ls_rdata 0x8899AABB.
REQ-043 Signed byte load, mem_data 0xF0xxxxxx -> ls_rdata 0xFFFFFFF0; unsigned half load, mem_data 0x8001xxxx -> ls_rdata 0x00008001.
REQ-044 Store word to 0x0000_0004 (flash) -> ls_done and ls_fault in the same cycle, mem_start never rises; store to 0x0100_0004 -> mem_is_write 1, num_bytes 4.
REQ-045 if_req and ls_req raised in the same cycle -> the load/store completes first, mem_start is low for at least 2 cycles, then the fetch completes.
REQ-046 rst asserted 3 cycles into BUSY -> mem_start 0 in the same cycle, no done pulses, clean fetch after release.
